alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_top.sv | 59 +++++
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// Module   : alu_pkg
// Brief    : Opcode map and arbiter FSM state encoding shared by the ALU arbiter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_ROL = 3'b111;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_top.sv
//------------------------------------------------------------------------------
// Module   : alu_top
// Brief    : Combinational 4-bit ALU producing a zero-extended 8-bit result.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_top
  import alu_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [2:0] op_i,
  output logic [7:0] result_o,
  output logic       dz_o
);

  logic [3:0] w_sub;
  logic [3:0] w_rol;

  assign w_sub = a_i - b_i;

  // Rotate A left by B[1:0]
  always_comb begin
    w_rol = a_i;
    case (b_i[1:0])
      2'd1:    w_rol = {a_i[2:0], a_i[3]};
      2'd2:    w_rol = {a_i[1:0], a_i[3:2]};
      2'd3:    w_rol = {a_i[0], a_i[3:1]};
      default: w_rol = a_i;
    endcase
  end

  always_comb begin
    result_o = 8'h00;
    dz_o     = 1'b0;
    case (op_i)
      OP_ADD: result_o = {4'h0, a_i} + {4'h0, b_i};
      OP_SUB: result_o = {4'h0, w_sub};
      OP_MUL: result_o = {4'h0, a_i} * {4'h0, b_i};
      OP_DIV: begin
        if (b_i == 4'h0) begin
          result_o = 8'hFF;
          dz_o     = 1'b1;
        end else begin
          result_o = {4'h0, a_i / b_i};
        end
      end
      OP_AND:  result_o = {4'h0, a_i & b_i};
      OP_OR:   result_o = {4'h0, a_i | b_i};
      OP_XOR:  result_o = {4'h0, a_i ^ b_i};
      OP_ROL:  result_o = {4'h0, w_rol};
      default: result_o = 8'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
//------------------------------------------------------------------------------
// Module   : alu_arbiter
// Brief    : Round-robin arbiter sharing one ALU between two requesters.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int MULDIV_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req1_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_id,
  output logic       rsp_dz
);

  localparam logic [CNT_W-1:0] c_md_load = CNT_W'(MULDIV_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic [7:0]       result_q, result_d;
  logic             rsp_id_q, rsp_id_d;
  logic             dz_q, dz_d;

  logic             w_grant_vld;
  logic             w_grant_id;
  logic             w_idle;
  logic             w_hs;
  logic [2:0]       w_sel_op;
  logic [7:0]       w_alu_result;
  logic             w_alu_dz;

  // Contention goes to whoever was not served last; a lone requester always wins
  always_comb begin
    w_grant_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      w_grant_id = ~last_q;
    end else begin
      w_grant_id = req1_valid;
    end
  end

  assign w_idle     = (state_q == ST_IDLE) && !rst;
  assign w_hs       = w_idle && w_grant_vld;
  assign req0_ready = w_hs && !w_grant_id;
  assign req1_ready = w_hs && w_grant_id;
  assign w_sel_op   = w_grant_id ? req1_op : req0_op;

  alu_top u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (w_alu_result),
    .dz_o     (w_alu_dz)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    id_d     = id_q;
    last_d   = last_q;
    result_d = result_q;
    rsp_id_d = rsp_id_q;
    dz_d     = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (w_hs) begin
          a_d     = w_grant_id ? req1_a : req0_a;
          b_d     = w_grant_id ? req1_b : req0_b;
          op_d    = w_sel_op;
          id_d    = w_grant_id;
          last_d  = w_grant_id;
          cnt_d   = ((w_sel_op == OP_MUL) || (w_sel_op == OP_DIV)) ? c_md_load : '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          result_d = w_alu_result;
          rsp_id_d = id_q;
          dz_d     = w_alu_dz;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= 4'h0;
      b_q      <= 4'h0;
      op_q     <= OP_ADD;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
      result_q <= 8'h00;
      rsp_id_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      id_q     <= id_d;
      last_q   <= last_d;
      result_q <= result_d;
      rsp_id_q <= rsp_id_d;
      dz_q     <= dz_d;
    end
  end

  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_result = result_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_dz     = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_arbiter
// Brief    : Self-checking bench for alu_arbiter against a behavioural model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_v  [2];
  logic [2:0] s_op [2];
  logic [3:0] s_a  [2];
  logic [3:0] s_b  [2];
  logic       rsp_ready = 1'b0;
  logic       ready0, ready1, rsp_valid, rsp_id, rsp_dz;
  logic [7:0] rsp_result;

  int n_checks = 0;
  int n_fail   = 0;
  int last_m   = 1;
  int g;

  always #5 clk = ~clk;

  alu_arbiter #(.MULDIV_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (s_v[0]),
    .req0_ready (ready0),
    .req0_a     (s_a[0]),
    .req0_b     (s_b[0]),
    .req0_op    (s_op[0]),
    .req1_valid (s_v[1]),
    .req1_ready (ready1),
    .req1_a     (s_a[1]),
    .req1_b     (s_b[1]),
    .req1_op    (s_op[1]),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .rsp_dz     (rsp_dz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {dz, result} straight from the opcode definitions
  function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, r, k;
    logic dz;
    ia = int'(a);
    ib = int'(b);
    r  = 0;
    dz = 1'b0;
    case (op)
      OP_ADD: r = ia + ib;
      OP_SUB: r = (ia - ib + 16) % 16;
      OP_MUL: r = ia * ib;
      OP_DIV: begin
        if (ib == 0) begin
          r  = 255;
          dz = 1'b1;
        end else begin
          r = ia / ib;
        end
      end
      OP_AND: r = ia & ib;
      OP_OR:  r = ia | ib;
      OP_XOR: r = ia ^ ib;
      OP_ROL: begin
        k = ib % 4;
        r = ((ia << k) | (ia >> (4 - k))) % 16;
      end
      default: r = 0;
    endcase
    return {dz, 8'(r)};
  endfunction

  task automatic set_req(input int id, input logic v, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b);
    s_v[id]  = v;
    s_op[id] = op;
    s_a[id]  = a;
    s_b[id]  = b;
  endtask

  // Entered just after requests are driven (a few ns past a negedge, state IDLE)
  task automatic run_round(input bit keep, input bit early, input int hold, output int gnt);
    int         exp_g, lat, exp_lat;
    logic [8:0] exp_r;
    #1;
    chk("one_ready", 32'(ready0 & ready1), 32'd0);
    if (s_v[0] && s_v[1]) exp_g = (last_m == 1) ? 0 : 1;
    else                  exp_g = s_v[0] ? 0 : 1;
    gnt = ready1 ? 1 : (ready0 ? 0 : -1);
    chk("grant", gnt, exp_g);
    if (gnt < 0) return;
    exp_r   = ref_alu(s_op[gnt], s_a[gnt], s_b[gnt]);
    exp_lat = (s_op[gnt] == OP_MUL || s_op[gnt] == OP_DIV) ? LAT + 1 : 2;
    last_m  = gnt;
    @(negedge clk);
    if (!keep) begin
      s_v[0] = 1'b0;
      s_v[1] = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      s_a[i]  = 4'($urandom);
      s_b[i]  = 4'($urandom);
      s_op[i] = 3'($urandom);
    end
    rsp_ready = early;
    #1;
    lat = 1;
    while (!rsp_valid && lat < 16) begin
      chk("busy_no_ready", {30'd0, ready0, ready1}, 32'd0);
      @(negedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("result", rsp_result, exp_r[7:0]);
    chk("id", rsp_id, gnt);
    chk("dz", rsp_dz, exp_r[8]);
    for (int h = 0; h < hold; h++) begin
      chk("done_no_ready", {30'd0, ready0, ready1}, 32'd0);
      @(negedge clk);
      #1;
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_result", rsp_result, exp_r[7:0]);
      chk("hold_id", rsp_id, gnt);
      chk("hold_dz", rsp_dz, exp_r[8]);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("rsp_released", rsp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit v0, v1, kp, er;
    set_req(0, 1'b1, OP_ADD, 4'h1, 4'h2);
    set_req(1, 1'b1, OP_ADD, 4'h3, 4'h4);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready0", ready0, 1'b0);
    chk("rst_ready1", ready1, 1'b0);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_result", rsp_result, 8'h00);
    chk("rst_id", rsp_id, 1'b0);
    chk("rst_dz", rsp_dz, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Continuous contention straight out of reset alternates 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, OP_ADD, 4'($urandom), 4'($urandom));
      set_req(1, 1'b1, OP_XOR, 4'($urandom), 4'($urandom));
      run_round(1'b1, 1'b0, 0, g);
      chk("rr_sequence", g, k % 2);
    end

    set_req(1, 1'b0, OP_ADD, 4'h0, 4'h0);
    set_req(0, 1'b1, OP_ADD, 4'h9, 4'h8);
    run_round(1'b0, 1'b0, 0, g);
    set_req(1, 1'b1, OP_MUL, 4'hF, 4'hF);
    run_round(1'b0, 1'b0, 0, g);
    set_req(0, 1'b1, OP_DIV, 4'h7, 4'h0);
    run_round(1'b0, 1'b0, 0, g);
    set_req(0, 1'b1, OP_DIV, 4'hC, 4'h3);
    run_round(1'b0, 1'b0, 0, g);
    set_req(1, 1'b1, OP_ROL, 4'h9, 4'h1);
    run_round(1'b0, 1'b0, 5, g);
    set_req(0, 1'b1, OP_SUB, 4'h2, 4'h5);
    run_round(1'b0, 1'b1, 0, g);

    repeat (40) begin
      v0 = 1'($urandom);
      v1 = v0 ? 1'($urandom) : 1'b1;
      kp = 1'($urandom);
      er = ($urandom % 4) == 0;
      set_req(0, v0, 3'($urandom), 4'($urandom), 4'($urandom));
      set_req(1, v1, 3'($urandom), 4'($urandom), 4'($urandom));
      run_round(kp, er, er ? 0 : int'($urandom % 4), g);
    end

    // Reset in the middle of a MUL from requester 0
    set_req(1, 1'b0, OP_ADD, 4'h0, 4'h0);
    set_req(0, 1'b1, OP_MUL, 4'hD, 4'h7);
    #1;
    chk("mul_accept", ready0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    s_v[1] = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_ready0", ready0, 1'b0);
    chk("midrst_ready1", ready1, 1'b0);
    chk("midrst_valid", rsp_valid, 1'b0);
    chk("midrst_result", rsp_result, 8'h00);
    chk("midrst_id", rsp_id, 1'b0);
    chk("midrst_dz", rsp_dz, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    s_v[0] = 1'b0;
    s_v[1] = 1'b0;
    last_m = 1;
    repeat (5) begin
      #1;
      chk("no_stale_rsp", rsp_valid, 1'b0);
      @(negedge clk);
    end
    set_req(0, 1'b1, OP_OR, 4'h5, 4'hA);
    set_req(1, 1'b1, OP_AND, 4'hF, 4'h3);
    run_round(1'b0, 1'b0, 0, g);
    chk("post_rst_grant", g, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
